// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha block core: state word packing,
// quarter-round index table, FSM encoding and the rotate helper.
package chacha_pkg;

    localparam int ROUND_CNT_W = 7;

    localparam logic [3:0][31:0] CHACHA_CONST = {
        32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865
    };

    typedef logic [15:0][31:0] state_t;

    // Entries 0..3 are the column rounds, 4..7 the diagonal rounds.
    localparam logic [3:0] QR_IDX [8][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15},
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fsm_e;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        rotl = (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/quarter_round.sv
// Combinational ChaCha quarter round on four 32-bit words.
module quarter_round
    import chacha_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] a_new,
    output logic [31:0] b_new,
    output logic [31:0] c_new,
    output logic [31:0] d_new
);

    logic [31:0] a1, b1, c1, d1;

    assign a1    = a + b;
    assign d1    = rotl(d ^ a1, 16);
    assign c1    = c + d1;
    assign b1    = rotl(b ^ c1, 12);
    assign a_new = a1 + b1;
    assign d_new = rotl(d1 ^ a_new, 8);
    assign c_new = c1 + d_new;
    assign b_new = rotl(b1 ^ c_new, 7);

endmodule

// File: rtl/chacha_block_core.sv
// Sequential ChaCha block function: QR_LANES quarter rounds per cycle over
// ROUNDS rounds, then a one-cycle feed-forward add of the input state.
module chacha_block_core
    import chacha_pkg::*;
#(
    parameter int ROUNDS    = 20,
    parameter int QR_LANES  = 4,
    parameter int ADD_INPUT = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_state,
    output logic         busy
);

    localparam int STEPS = ROUNDS * 4 / QR_LANES;
    localparam logic [ROUND_CNT_W-1:0] LAST_STEP = ROUND_CNT_W'(STEPS - 1);

    generate
        if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
            $error("chacha_block_core: ROUNDS must be 8, 12 or 20");
        end
        if (!(QR_LANES == 1 || QR_LANES == 2 || QR_LANES == 4)) begin : g_bad_lanes
            $error("chacha_block_core: QR_LANES must be 1, 2 or 4");
        end
    endgenerate

    fsm_e                   state, state_next;
    logic [ROUND_CNT_W-1:0] step;
    state_t                 w, s, w_next, out_reg;
    logic                   load, run, finish;

    logic [2:0]  lane_q [QR_LANES];
    logic [31:0] qa [QR_LANES], qb [QR_LANES], qc [QR_LANES], qd [QR_LANES];
    logic [31:0] ra [QR_LANES], rb [QR_LANES], rc [QR_LANES], rd [QR_LANES];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        run        = 1'b0;
        finish     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = reset_n;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                busy = 1'b1;
                run  = 1'b1;
                if (step == LAST_STEP) state_next = FINAL;
            end
            FINAL: begin
                busy       = 1'b1;
                finish     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The schedule index only depends on the low three step bits because it repeats every 8 quarter rounds.
    always_comb begin
        for (int l = 0; l < QR_LANES; l++) begin
            lane_q[l] = 3'(step[2:0] * 3'(QR_LANES)) + 3'(l);
            qa[l]     = w[QR_IDX[lane_q[l]][0]];
            qb[l]     = w[QR_IDX[lane_q[l]][1]];
            qc[l]     = w[QR_IDX[lane_q[l]][2]];
            qd[l]     = w[QR_IDX[lane_q[l]][3]];
        end
    end

    generate
        for (genvar l = 0; l < QR_LANES; l++) begin : g_lane
            quarter_round u_qr (
                .a     (qa[l]),
                .b     (qb[l]),
                .c     (qc[l]),
                .d     (qd[l]),
                .a_new (ra[l]),
                .b_new (rb[l]),
                .c_new (rc[l]),
                .d_new (rd[l])
            );
        end
    endgenerate

    always_comb begin
        w_next = w;
        for (int l = 0; l < QR_LANES; l++) begin
            w_next[QR_IDX[lane_q[l]][0]] = ra[l];
            w_next[QR_IDX[lane_q[l]][1]] = rb[l];
            w_next[QR_IDX[lane_q[l]][2]] = rc[l];
            w_next[QR_IDX[lane_q[l]][3]] = rd[l];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w       <= '0;
            s       <= '0;
            step    <= '0;
            out_reg <= '0;
        end else begin
            if (load) begin
                w <= in_state;
                s <= in_state;
            end else if (run) begin
                w <= w_next;
            end
            if (run) step <= (step == LAST_STEP) ? '0 : step + 1'b1;
            if (finish) begin
                for (int i = 0; i < 16; i++) begin
                    out_reg[i] <= (ADD_INPUT != 0) ? w[i] + s[i] : w[i];
                end
            end
        end
    end

    assign out_state = out_reg;

endmodule
